// File: rtl/video_timing_gen.sv
// video_timing_gen
// Raster timing and test-pattern source feeding one TMDS encoder channel.
// Free-running horizontal/vertical counters are decoded into disp_ena,
// {vsync, hsync} and an 8-bit test pattern. Every output is registered on
// the same edge, so all outputs stay aligned with each other.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   en          run enable; when low, counters clear and outputs idle
//   pattern_sel 00 solid, 01 ramp, 10 colour bars, 11 checkerboard
//   disp_ena    active-video flag
//   control     {vsync, hsync}; asserted level is SYNC_POL
//   pix_data    pixel value, forced to 0 outside active video
//   frame_start one-cycle pulse on the beat at position (0,0)
//   h_pos/v_pos raster position described by the current output beat
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        SYNC_POL  = 1'b0,
    parameter logic [7:0]  SOLID_VAL = 8'h80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        disp_ena,
    output logic [1:0]  control,
    output logic [7:0]  pix_data,
    output logic        frame_start,
    output logic [11:0] h_pos,
    output logic [10:0] v_pos
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] HT1 = 12'(H_TOTAL - 1);
    localparam logic [11:0] BW1 = 12'(BAR_W - 1);
    localparam logic [10:0] VA  = 11'(V_ACTIVE);
    localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] VT1 = 11'(V_TOTAL - 1);

    logic [11:0] hc;
    logic [10:0] vc;
    logic [11:0] bar_cnt;   // clocks elapsed inside the current bar
    logic [2:0]  bar_idx;   // current bar number, avoids a divide by BAR_W
    logic [1:0]  pat_q;

    logic       first, active, hs, vs, h_wrap, v_wrap;
    logic [1:0] pat_eff;
    logic [7:0] pix_pat;

    always_comb begin
        first  = (hc == 12'd0) && (vc == 11'd0);
        active = (hc < HA) && (vc < VA);
        hs     = (hc >= HS0) && (hc < HS1);
        vs     = (vc >= VS0) && (vc < VS1);
        h_wrap = (hc == HT1);
        v_wrap = (vc == VT1);
        // The (0,0) beat already belongs to the new frame, so it uses the
        // selection being latched on this very edge.
        pat_eff = first ? pattern_sel : pat_q;
        pix_pat = SOLID_VAL;
        case (pat_eff)
            2'b00: pix_pat = SOLID_VAL;
            2'b01: pix_pat = hc[7:0];
            2'b10: pix_pat = ~{bar_idx, 5'b0};
            2'b11: pix_pat = {8{hc[3] ^ vc[3]}};
            default: pix_pat = SOLID_VAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc          <= '0;
            vc          <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            pat_q       <= 2'b00;
            disp_ena    <= 1'b0;
            control     <= {~SYNC_POL, ~SYNC_POL};
            pix_data    <= 8'h00;
            frame_start <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
        end else if (!en) begin
            // pat_q deliberately holds so a restart keeps the last pattern
            hc          <= '0;
            vc          <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            disp_ena    <= 1'b0;
            control     <= {~SYNC_POL, ~SYNC_POL};
            pix_data    <= 8'h00;
            frame_start <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
        end else begin
            disp_ena    <= active;
            control     <= {vs ? SYNC_POL : ~SYNC_POL, hs ? SYNC_POL : ~SYNC_POL};
            pix_data    <= active ? pix_pat : 8'h00;
            frame_start <= first;
            h_pos       <= hc;
            v_pos       <= vc;
            if (first) pat_q <= pattern_sel;

            if (h_wrap) begin
                hc      <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                vc      <= v_wrap ? 11'd0 : vc + 11'd1;
            end else begin
                hc <= hc + 12'd1;
                if (bar_cnt == BW1) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 12'd1;
                end
            end
        end
    end

endmodule
